// File: rtl/wb_queue.sv
// Writeback queue: buffers register writes from the MEM stage and issues them in order
// to the register bank, tracking which registers still have writes pending.
module wb_queue #(
    parameter int unsigned ARQ   = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_wb_enable,
    input  logic [ARQ-1:0] in_result,
    input  logic [ARQ-1:0] in_imm,
    input  logic           in_sel_imm,
    input  logic [2:0]     in_dest,
    input  logic           wb_hold,
    output logic           wr_register,
    output logic [ARQ-1:0] wb_result,
    output logic [ARQ-1:0] wb_imm,
    output logic           wb_sel_imm,
    output logic [2:0]     wb_dest,
    output logic [7:0]     busy,
    output logic [2:0]     count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned NumRegs = 8;

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] pend_q [NumRegs];
    logic [CntW-1:0] pend_d [NumRegs];

    logic [ARQ-1:0] result_mem [DEPTH];
    logic [ARQ-1:0] imm_mem    [DEPTH];
    logic           sel_mem    [DEPTH];
    logic [2:0]     dest_mem   [DEPTH];

    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic [2:0]     head_dest;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count_q == CntW'(DEPTH));
    assign empty     = (count_q == '0);
    // Accepted offers without a real write are consumed here and never stored.
    assign push      = in_valid & ~full & in_wb_enable;
    assign pop       = ~empty & ~wb_hold;
    assign head_dest = dest_mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // A push and a pop hitting the same register in one cycle cancel out.
    always_comb begin
        for (int d = 0; d < NumRegs; d++) begin
            pend_d[d] = pend_q[d];
            if ((push && in_dest == 3'(d)) && !(pop && head_dest == 3'(d))) begin
                pend_d[d] = pend_q[d] + 1'b1;
            end else if (!(push && in_dest == 3'(d)) && (pop && head_dest == 3'(d))) begin
                pend_d[d] = pend_q[d] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int d = 0; d < NumRegs; d++) begin
                pend_q[d] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int d = 0; d < NumRegs; d++) begin
                pend_q[d] <= pend_d[d];
            end
        end
    end

    // Storage holds no control state, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            result_mem[wr_ptr_q] <= in_result;
            imm_mem[wr_ptr_q]    <= in_imm;
            sel_mem[wr_ptr_q]    <= in_sel_imm;
            dest_mem[wr_ptr_q]   <= in_dest;
        end
    end

    // Outputs are forced to their idle values while reset is asserted.
    assign in_ready    = ~rst | ~full;
    assign wr_register = rst & pop;
    assign count       = rst ? 3'(count_q) : 3'd0;

    always_comb begin
        wb_result  = '0;
        wb_imm     = '0;
        wb_sel_imm = 1'b0;
        wb_dest    = '0;
        if (rst && !empty) begin
            wb_result  = result_mem[rd_ptr_q];
            wb_imm     = imm_mem[rd_ptr_q];
            wb_sel_imm = sel_mem[rd_ptr_q];
            wb_dest    = head_dest;
        end
    end

    always_comb begin
        busy = '0;
        for (int d = 0; d < NumRegs; d++) begin
            busy[d] = rst & (pend_q[d] != '0);
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: a negedge monitor runs a reference FIFO model (scoreboard) every cycle
// while scenario tasks drive stimulus and check the specific behaviours of each scenario.
module tb_wb_queue;

    localparam int unsigned ARQ   = 16;
    localparam int unsigned DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic           in_wb_enable;
    logic [ARQ-1:0] in_result;
    logic [ARQ-1:0] in_imm;
    logic           in_sel_imm;
    logic [2:0]     in_dest;
    logic           wb_hold;
    logic           wr_register;
    logic [ARQ-1:0] wb_result;
    logic [ARQ-1:0] wb_imm;
    logic           wb_sel_imm;
    logic [2:0]     wb_dest;
    logic [7:0]     busy;
    logic [2:0]     count;

    typedef struct packed {
        logic [2:0]     dest;
        logic [ARQ-1:0] res;
        logic [ARQ-1:0] imm;
        logic           sel;
    } ent_t;

    ent_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic       m_ready;
    logic       m_pop;
    logic [7:0] m_busy;
    logic [2:0] m_count;
    ent_t       m_head;

    always #5 clk = ~clk;

    wb_queue #(
        .ARQ   (ARQ),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_wb_enable (in_wb_enable),
        .in_result    (in_result),
        .in_imm       (in_imm),
        .in_sel_imm   (in_sel_imm),
        .in_dest      (in_dest),
        .wb_hold      (wb_hold),
        .wr_register  (wr_register),
        .wb_result    (wb_result),
        .wb_imm       (wb_imm),
        .wb_sel_imm   (wb_sel_imm),
        .wb_dest      (wb_dest),
        .busy         (busy),
        .count        (count)
    );

    // Scoreboard: compare against the model, then apply this cycle's pop and push to it.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (wr_register !== 1'b0 || busy !== 8'h00 || count !== 3'd0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rst_outputs: wr=%b busy=%h count=%0d ready=%b, required 0 00 0 1",
                         wr_register, busy, count, in_ready);
            end
            checks++;
            if (wb_dest !== 3'd0 || wb_result !== '0 || wb_imm !== '0 || wb_sel_imm !== 1'b0) begin
                errors++;
                $display("FAIL rst_head: dest=%0d res=%h imm=%h sel=%b, required all 0",
                         wb_dest, wb_result, wb_imm, wb_sel_imm);
            end
            exp_q.delete();
        end else begin
            m_ready = (exp_q.size() != DEPTH);
            m_pop   = (exp_q.size() != 0) && !wb_hold;
            m_count = 3'(exp_q.size());
            m_busy  = '0;
            foreach (exp_q[i]) m_busy[exp_q[i].dest] = 1'b1;
            m_head = '0;
            if (exp_q.size() != 0) m_head = exp_q[0];
            checks++;
            if (in_ready !== m_ready) begin
                errors++;
                $display("FAIL sb_ready: got %b required %b", in_ready, m_ready);
            end
            checks++;
            if (wr_register !== m_pop) begin
                errors++;
                $display("FAIL sb_wr_register: got %b required %b", wr_register, m_pop);
            end
            checks++;
            if (count !== m_count) begin
                errors++;
                $display("FAIL sb_count: got %0d required %0d", count, m_count);
            end
            checks++;
            if (busy !== m_busy) begin
                errors++;
                $display("FAIL sb_busy: got %h required %h", busy, m_busy);
            end
            checks++;
            if (wb_dest !== m_head.dest || wb_result !== m_head.res || wb_imm !== m_head.imm ||
                wb_sel_imm !== m_head.sel) begin
                errors++;
                $display("FAIL sb_head: got d=%0d r=%h i=%h s=%b required d=%0d r=%h i=%h s=%b",
                         wb_dest, wb_result, wb_imm, wb_sel_imm,
                         m_head.dest, m_head.res, m_head.imm, m_head.sel);
            end
            if (m_pop) void'(exp_q.pop_front());
            if (in_valid && m_ready && in_wb_enable) begin
                exp_q.push_back('{dest: in_dest, res: in_result, imm: in_imm, sel: in_sel_imm});
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic en, input logic [2:0] d,
                         input logic [ARQ-1:0] r, input logic [ARQ-1:0] im, input logic s);
        in_valid     = v;
        in_wb_enable = en;
        in_dest      = d;
        in_result    = r;
        in_imm       = im;
        in_sel_imm   = s;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'd0, '0, '0, 1'b0);
    endtask

    task automatic drain();
        idle();
        wb_hold = 1'b0;
        for (int i = 0; i < 3 * DEPTH && exp_q.size() != 0; i++) next_cycle();
        @(negedge clk);
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL drain_timeout: count=%0d required 0", count);
        end
        next_cycle();
    endtask

    task automatic test_reset();
        @(negedge clk);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (count !== 3'd0 || busy !== 8'h00 || in_ready !== 1'b1 || wr_register !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: count=%0d busy=%h ready=%b wr=%b, required 0 00 1 0",
                     count, busy, in_ready, wr_register);
        end
        next_cycle();
    endtask

    task automatic test_single();
        wb_hold = 1'b0;
        drive(1'b1, 1'b1, 3'd3, 16'h1234, 16'h0000, 1'b0);
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (wr_register !== 1'b1 || wb_dest !== 3'd3 || wb_result !== 16'h1234 ||
            busy !== 8'h08) begin
            errors++;
            $display("FAIL single_issue: wr=%b dest=%0d res=%h busy=%h, required 1 3 1234 08",
                     wr_register, wb_dest, wb_result, busy);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (busy !== 8'h00 || count !== 3'd0 || wr_register !== 1'b0) begin
            errors++;
            $display("FAIL single_after: busy=%h count=%0d wr=%b, required 00 0 0",
                     busy, count, wr_register);
        end
        next_cycle();
    endtask

    task automatic test_hold_fill();
        wb_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b1, 3'(i), ARQ'($urandom), ARQ'($urandom), 1'(i));
            next_cycle();
        end
        drive(1'b1, 1'b1, 3'd6, 16'hdead, 16'hbeef, 1'b1);
        @(negedge clk);
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0 || busy !== 8'h1E || wr_register !== 1'b0) begin
            errors++;
            $display("FAIL hold_full: count=%0d ready=%b busy=%h wr=%b, required 4 0 1e 0",
                     count, in_ready, busy, wr_register);
        end
        next_cycle();
        idle();
        wb_hold = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_register !== 1'b1 || wb_dest !== 3'd1) begin
            errors++;
            $display("FAIL hold_first_pop: wr=%b dest=%0d, required 1 1", wr_register, wb_dest);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || count !== 3'd3 || wb_dest !== 3'd2) begin
            errors++;
            $display("FAIL hold_after_pop: ready=%b count=%0d dest=%0d, required 1 3 2",
                     in_ready, count, wb_dest);
        end
        drain();
    endtask

    task automatic test_same_dest();
        wb_hold = 1'b1;
        drive(1'b1, 1'b1, 3'd5, 16'h0001, 16'h0000, 1'b0);
        next_cycle();
        drive(1'b1, 1'b1, 3'd5, 16'h0002, 16'h0000, 1'b0);
        next_cycle();
        wb_hold = 1'b0;
        drive(1'b1, 1'b1, 3'd5, 16'h0003, 16'h0000, 1'b0);
        @(negedge clk);
        checks++;
        if (busy !== 8'h20 || count !== 3'd2 || wr_register !== 1'b1) begin
            errors++;
            $display("FAIL same_dest_overlap: busy=%h count=%0d wr=%b, required 20 2 1",
                     busy, count, wr_register);
        end
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (busy !== 8'h20 || count !== 3'd2) begin
            errors++;
            $display("FAIL same_dest_2left: busy=%h count=%0d, required 20 2", busy, count);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (busy !== 8'h20 || count !== 3'd1) begin
            errors++;
            $display("FAIL same_dest_1left: busy=%h count=%0d, required 20 1", busy, count);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (busy !== 8'h00 || count !== 3'd0) begin
            errors++;
            $display("FAIL same_dest_done: busy=%h count=%0d, required 00 0", busy, count);
        end
        next_cycle();
    endtask

    task automatic test_discard();
        wb_hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 3'(i + 5), ARQ'($urandom), ARQ'($urandom), 1'b1);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || count !== 3'd0 || wr_register !== 1'b0) begin
                errors++;
                $display("FAIL discard: ready=%b count=%0d wr=%b, required 1 0 0",
                         in_ready, count, wr_register);
            end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_reset_midflight();
        wb_hold = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 3'(2 * i), ARQ'($urandom), ARQ'($urandom), 1'b0);
            next_cycle();
        end
        rst     = 1'b0;
        wb_hold = 1'b0;
        drive(1'b1, 1'b1, 3'd7, 16'h7777, 16'h0000, 1'b0);
        @(negedge clk);
        checks++;
        if (wr_register !== 1'b0 || busy !== 8'h00 || count !== 3'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midflight_rst: wr=%b busy=%h count=%0d ready=%b, required 0 00 0 1",
                     wr_register, busy, count, in_ready);
        end
        next_cycle();
        rst = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (wr_register !== 1'b0 || busy !== 8'h00 || count !== 3'd0) begin
                errors++;
                $display("FAIL midflight_stale: wr=%b busy=%h count=%0d, required 0 00 0",
                         wr_register, busy, count);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        wb_hold = 1'b0;
        drive(1'b1, 1'b1, 3'($urandom_range(0, 7)), ARQ'($urandom), ARQ'($urandom), 1'b0);
        next_cycle();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 3'($urandom_range(0, 7)), ARQ'($urandom), ARQ'($urandom),
                  1'($urandom_range(0, 1)));
            @(negedge clk);
            checks++;
            if (count !== 3'd1 || wr_register !== 1'b1) begin
                errors++;
                $display("FAIL b2b_steady: cycle %0d count=%0d wr=%b, required 1 1",
                         i, count, wr_register);
            end
            next_cycle();
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  3'($urandom_range(0, 7)), ARQ'($urandom), ARQ'($urandom),
                  1'($urandom_range(0, 1)));
            wb_hold = ($urandom_range(0, 2) == 0);
            next_cycle();
        end
        drain();
    endtask

    initial begin
        rst     = 1'b0;
        wb_hold = 1'b0;
        idle();
        test_reset();
        test_single();
        test_hold_fill();
        test_same_dest();
        test_discard();
        test_reset_midflight();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter ARQ, default 16: datapath width of result and immediate.
REQ-002 SHALL have parameter DEPTH, default 4: pending-write entries; power of two only.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-low.
REQ-005 SHALL have port in_valid  in  1  producer (MEM stage) offers a writeback this cycle.
REQ-006 SHALL have port in_ready  out  1  queue can accept this cycle.
REQ-007 SHALL have port in_wb_enable  in  1  offered instruction really writes a register.
REQ-008 SHALL have port in_result  in  ARQ  ALU/memory result.
REQ-009 SHALL have port in_imm  in  ARQ  zero-extended immediate.
REQ-010 SHALL have port in_sel_imm  in  1  1 = write immediate, 0 = write result.
REQ-011 SHALL have port in_dest  in  3  destination register index.
REQ-012 SHALL have port wb_hold  in  1  register bank not writable this cycle.
REQ-013 SHALL have port wr_register  out  1  register-bank write strobe.
REQ-014 SHALL have port wb_result  out  ARQ  head-entry result.
REQ-015 SHALL have port wb_imm  out  ARQ  head-entry immediate.
REQ-016 SHALL have port wb_sel_imm  out  1  head-entry select.
REQ-017 SHALL have port wb_dest  out  3  head-entry destination.
REQ-018 SHALL have port busy  out  8  bit d = at least one queued write to register d.
REQ-019 SHALL have port count  out  3  occupied entries, 0..DEPTH.

Function
REQ-020 SHALL define accept = in_valid & in_ready; push = accept & in_wb_enable; accept with in_wb_enable=0 is consumed and discarded.
REQ-021 SHALL drive in_ready = (count != DEPTH), registered-state only; no combinational path from wb_hold or in_valid.
REQ-022 SHALL define pop = (count != 0) & ~wb_hold; wr_register = pop, combinational.
REQ-023 SHALL present head entry on wb_result/wb_imm/wb_sel_imm/wb_dest whenever count != 0; all four SHALL be 0 when count == 0.
REQ-024 SHALL store a pushed entry at tail on the clock edge; earliest wr_register for it is the next cycle (latency 1 when queue empty and wb_hold=0).
REQ-025 SHALL issue entries strictly in push order, at most one pop and one push per cycle.
REQ-026 SHALL use wrapping read/write pointers modulo DEPTH; count += push - pop.
REQ-027 SHALL allow simultaneous push and pop when full is not asserted; when full, in_ready=0 so no push, pop proceeds normally and frees a slot for the following cycle.
REQ-028 SHALL keep per-register pending counter (0..DEPTH): +1 on push to d, -1 on pop of d, unchanged when both target d in the same cycle; busy[d] = counter != 0, registered.
REQ-029 SHALL keep all state unchanged while wb_hold=1, except pushes.
REQ-030 SHALL ignore in_* data when accept=0.

Reset
REQ-031 SHALL, on rising clk with rst=0, clear pointers, count, and all pending counters; storage array need not be cleared.
REQ-032 SHALL, during reset cycle and after: wr_register=0, busy=0, count=0, in_ready=1, wb_* outputs 0.
REQ-033 SHALL give reset priority over simultaneous push/pop; in-flight entries are discarded.

Verification
REQ-034 Empty queue, push {dest=3, result=0x1234, sel_imm=0}, wb_hold=0 -> next cycle wr_register=1, wb_dest=3, wb_result=0x1234, busy[3]=1 that cycle, busy=0 and count=0 after.
REQ-035 wb_hold=1, push dests 1,2,3,4 -> count=4, in_ready=0, busy=0x1E; release hold -> four strobes in order 1,2,3,4 on consecutive cycles, in_ready=1 after first pop.
REQ-036 Push dest=5 twice, then pop one while pushing dest=5 -> busy[5] stays 1 until third pop, then 0.
REQ-037 in_valid=1, in_wb_enable=0 -> in_ready=1, count unchanged, no wr_register.
REQ-038 Queue holding 3 entries, rst=0 for one cycle concurrent with push -> count=0, busy=0, wr_register=0, no stale entry issued after release.
REQ-039 Continuous push/pop for 20 cycles with random dests -> pointer wrap, count stays 1, strobe order and data match a reference FIFO model.
